// File: rtl/ftdi_sync_fifo_responder_if.sv
// FT245-style synchronous FIFO pin bundle.
// The master modport is the FPGA-side controller; the slave modport is the device-side responder.
interface ftdi_sync_fifo_responder_if;
    logic       ftdi_rxf_n;
    logic       ftdi_txe_n;
    logic       ftdi_rd_n;
    logic       ftdi_oe_n;
    logic       ftdi_wr_n;
    logic [7:0] ftdi_data_in;
    logic [7:0] ftdi_data_out;
    logic       ftdi_data_oe;

    modport master (
        input  ftdi_rxf_n, ftdi_txe_n, ftdi_data_out, ftdi_data_oe,
        output ftdi_rd_n, ftdi_oe_n, ftdi_wr_n, ftdi_data_in
    );

    modport slave (
        output ftdi_rxf_n, ftdi_txe_n, ftdi_data_out, ftdi_data_oe,
        input  ftdi_rd_n, ftdi_oe_n, ftdi_wr_n, ftdi_data_in
    );
endinterface

// File: rtl/ftdi_sync_fifo_responder.sv
// Device-side FT245 synchronous FIFO responder with host byte streams and FWFT buffers.
// Define FTDI_RESP_ERRCHK_EN to build the read FSM and the sticky protocol checker behind proto_err.
module ftdi_sync_fifo_responder #(
    parameter int unsigned RX_DEPTH_LOG2 = 4,
    parameter int unsigned TX_DEPTH_LOG2 = 4,
    parameter int unsigned TX_BURST      = 8,
    parameter int unsigned TX_GAP        = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    ftdi_sync_fifo_responder_if.slave     ftdi,
    input  logic [7:0]                    host_tx_data,
    input  logic                          host_tx_valid,
    output logic                          host_tx_ready,
    output logic [7:0]                    host_rx_data,
    output logic                          host_rx_valid,
    input  logic                          host_rx_ready,
    output logic [15:0]                   rx_count,
    output logic [15:0]                   tx_count,
    output logic                          proto_err
);
    localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int unsigned RX_CW    = RX_DEPTH_LOG2 + 1;
    localparam int unsigned TX_CW    = TX_DEPTH_LOG2 + 1;
    localparam int unsigned BURST_W  = (TX_BURST < 2) ? 1 : $clog2(TX_BURST);
    localparam int unsigned GAP_W    = (TX_GAP < 2) ? 1 : $clog2(TX_GAP + 1);

    logic [7:0]               rx_mem [RX_DEPTH];
    logic [7:0]               tx_mem [TX_DEPTH];
    logic [RX_DEPTH_LOG2-1:0] rx_wptr, rx_rptr;
    logic [TX_DEPTH_LOG2-1:0] tx_wptr, tx_rptr;
    logic [RX_CW-1:0]         rx_occ, rx_occ_next;
    logic [TX_CW-1:0]         tx_occ, tx_occ_next;
    logic [BURST_W-1:0]       burst_cnt;
    logic [GAP_W-1:0]         gap_cnt, gap_cnt_next;
    logic                     rx_push, rx_pop, tx_push, tx_pop, burst_done;

    // A write overlapping a read strobe is dropped; the read wins.
    assign rx_push    = host_tx_valid & host_tx_ready;
    assign rx_pop     = ~ftdi.ftdi_rd_n & ~ftdi.ftdi_oe_n & ~ftdi.ftdi_rxf_n;
    assign tx_push    = ~ftdi.ftdi_wr_n & ~ftdi.ftdi_txe_n & ftdi.ftdi_rd_n;
    assign tx_pop     = host_rx_valid & host_rx_ready;
    assign burst_done = (TX_BURST != 0) && tx_push && (burst_cnt == BURST_W'(TX_BURST - 1));

    assign ftdi.ftdi_data_oe  = ~ftdi.ftdi_oe_n;
    assign ftdi.ftdi_data_out = ftdi.ftdi_rxf_n ? 8'h00 : rx_mem[rx_rptr];
    assign host_rx_data       = host_rx_valid ? tx_mem[tx_rptr] : 8'h00;

    // Next occupancies and gap countdown feed the registered flags so they are exact every cycle.
    always_comb begin
        rx_occ_next  = rx_occ + RX_CW'(rx_push) - RX_CW'(rx_pop);
        tx_occ_next  = tx_occ + TX_CW'(tx_push) - TX_CW'(tx_pop);
        gap_cnt_next = gap_cnt;
        if (burst_done) begin
            gap_cnt_next = GAP_W'(TX_GAP);
        end else if (gap_cnt != '0) begin
            gap_cnt_next = gap_cnt - GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr         <= '0;
            rx_rptr         <= '0;
            tx_wptr         <= '0;
            tx_rptr         <= '0;
            rx_occ          <= '0;
            tx_occ          <= '0;
            burst_cnt       <= '0;
            gap_cnt         <= '0;
            ftdi.ftdi_rxf_n <= 1'b1;
            ftdi.ftdi_txe_n <= 1'b1;
            host_tx_ready   <= 1'b0;
            host_rx_valid   <= 1'b0;
            rx_count        <= 16'd0;
            tx_count        <= 16'd0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + RX_DEPTH_LOG2'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + RX_DEPTH_LOG2'(1);
            if (tx_push) tx_wptr <= tx_wptr + TX_DEPTH_LOG2'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + TX_DEPTH_LOG2'(1);
            if (rx_pop)  rx_count <= rx_count + 16'd1;
            if (tx_push) tx_count <= tx_count + 16'd1;
            if (burst_done) begin
                burst_cnt <= '0;
            end else if (tx_push) begin
                burst_cnt <= burst_cnt + BURST_W'(1);
            end
            rx_occ          <= rx_occ_next;
            tx_occ          <= tx_occ_next;
            gap_cnt         <= gap_cnt_next;
            ftdi.ftdi_rxf_n <= (rx_occ_next == '0);
            ftdi.ftdi_txe_n <= (tx_occ_next == TX_CW'(TX_DEPTH)) || (gap_cnt_next != '0);
            host_tx_ready   <= (rx_occ_next != RX_CW'(RX_DEPTH));
            host_rx_valid   <= (tx_occ_next != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr] <= host_tx_data;
        if (tx_push) tx_mem[tx_wptr] <= ftdi.ftdi_data_in;
    end

`ifdef FTDI_RESP_ERRCHK_EN
    typedef enum logic [1:0] {RD_IDLE, RD_OE, RD_STREAM} rd_state_t;

    rd_state_t rd_state, rd_state_next;
    logic      err_c;

    always_ff @(posedge clk) begin
        if (rst) rd_state <= RD_IDLE;
        else     rd_state <= rd_state_next;
    end

    // Tracks OE-before-RD turnaround; an empty buffer with RD released always returns to idle.
    always_comb begin
        rd_state_next = rd_state;
        if (ftdi.ftdi_rxf_n && ftdi.ftdi_rd_n) begin
            rd_state_next = RD_IDLE;
        end else begin
            case (rd_state)
                RD_IDLE:   if (!ftdi.ftdi_oe_n) rd_state_next = RD_OE;
                RD_OE: begin
                    if (ftdi.ftdi_oe_n)       rd_state_next = RD_IDLE;
                    else if (!ftdi.ftdi_rd_n) rd_state_next = RD_STREAM;
                end
                RD_STREAM: if (ftdi.ftdi_oe_n) rd_state_next = RD_IDLE;
                default:   rd_state_next = RD_IDLE;
            endcase
        end
    end

    always_comb begin
        err_c = 1'b0;
        if (!ftdi.ftdi_rd_n && (rd_state == RD_IDLE)) err_c = 1'b1;
        if (!ftdi.ftdi_rd_n && ftdi.ftdi_rxf_n)       err_c = 1'b1;
        if (!ftdi.ftdi_wr_n && (!ftdi.ftdi_oe_n || ftdi.ftdi_txe_n || !ftdi.ftdi_rd_n)) err_c = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)        proto_err <= 1'b0;
        else if (err_c) proto_err <= 1'b1;
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule
